text_line_renderer: RTL
=======================

Name: text_line_renderer

Overview:
- Parametrised successor to the single-glyph lookup: holds a writable line of N_CHARS character codes and renders it as a scaled text box at a programmable screen origin.
- Consumes the VGA pixel coordinate stream and returns a pipelined, valid-tagged 1-bit "text pixel on" flag for the colour mixer.
- Adds a clear engine, integer power-of-two scaling and an optional per-character blink.

Parameters:
- N_CHARS, 16, characters in the line buffer (≥2, power of two)
- SCALE_LOG2, 1, glyph magnification = 2^SCALE_LOG2 (0..3)
- X_W, 10, pixel x width
- Y_W, 10, pixel y width
- BLINK_LOG2, 5, blink half-period = 2^BLINK_LOG2 frames (BLINK_EN only)

Ports:
- sys_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one buffer entry
- wr_addr  in  $clog2(N_CHARS)  entry index
- wr_code  in  5  character code: 0–25 = A–Z, 26 = space, 27–31 = blank
- wr_blink  in  1  blink attribute for entry (ignored without BLINK_EN)
- clr_i  in  1  pulse: start clearing the buffer to space
- busy_o  out  1  clear in progress
- org_x  in  X_W  box left edge
- org_y  in  Y_W  box top edge
- frame_start  in  1  one-cycle pulse per frame
- pix_valid_i  in  1  pixel coordinate valid
- pix_x  in  X_W  pixel x
- pix_y  in  Y_W  pixel y
- pix_valid_o  out  1  pix_valid_i delayed by 3 cycles
- pix_on_o  out  1  text pixel lit

Behaviour:
- Reset: every buffer entry = 26 (space), blink bits = 0, state IDLE, busy_o = 0, pix_valid_o = 0, pix_on_o = 0, pipeline valids = 0, frame counter = 0.
- Font: fixed 16×16 uppercase block-letter ROM, 16-bit row word per glyph row. Column 0 is the leftmost pixel and the MSB of the row word. Codes 26–31 produce all zeros.
- Box geometry:
  - width W = N_CHARS·16·2^S; height H = 16·2^S, where S = SCALE_LOG2.
  - Inside when org_x ≤ pix_x < org_x+W and org_y ≤ pix_y < org_y+H.
  - Comparisons are unsigned at X_W+1 / Y_W+1 bits, so boxes that overrun the screen edge never wrap.
- Pipeline (fixed latency 3, one pixel accepted per cycle, no backpressure):
  - S1 registers dx = pix_x−org_x, dy = pix_y−org_y and the inside flag.
  - S2 computes char = dx>>(4+S), col = (dx>>S)&15, row = (dy>>S)&15, and registers the buffer entry at char.
  - S3 registers ROM[code][row][15−col] AND inside AND NOT blank_phase into pix_on_o.
  - pix_valid_o follows pix_valid_i through the same stages. pix_on_o = 0 whenever its valid is 0.
- Write port: a write lands at the clock edge. An S2 read of the same entry in that same cycle returns the old value.
- Clear FSM:
  - IDLE: clr_i=1 → CLEAR, counter=0, busy_o=1.
  - CLEAR: each cycle write entry[counter] = 26 and blink = 0, then increment. When counter = N_CHARS−1 the FSM writes the last entry and returns to IDLE; busy_o drops on the following cycle.
  - A clear therefore takes exactly N_CHARS cycles.
  - In CLEAR, wr_en is ignored and clr_i is ignored (no restart).
  - wr_en and clr_i in the same IDLE cycle: the clear wins and the write is dropped.
  - Rendering continues during a clear and may show mixed content.
- Reset mid-clear: reset values apply immediately (asynchronous); the FSM returns to IDLE.
- org_x / org_y changes take effect for pixels entering S1 on or after the change.

Optional Feature:
- Macro: TEXT_LINE_BLINK_EN.
- Defined:
  - A frame counter of BLINK_LOG2+1 bits increments on frame_start and wraps.
  - blank_phase = counter MSB AND the blink bit of the entry read in S2. Blink bits are written from wr_blink on every write.
- Undefined:
  - No counter and no blink storage; blank_phase = 0.
  - wr_blink and frame_start stay in the port list and are ignored.

Test Plan:
- Reset, then stream pix (0..639, 0..479) with org (100,50) → pix_on_o = 0 everywhere; pix_valid_o is pix_valid_i delayed exactly 3 cycles.
- SCALE_LOG2=1, write code 0 ('A') at entry 0, org (100,50) → pix (106,50) and (107,51) give 1; (105,50) gives 0; (100+512, 50) gives 0 (outside W=512).
- Write code 1 at entry 3 in the same cycle that S2 reads entry 3 → that pixel uses the old code 26 (0); the next frame shows the glyph.
- Fill all entries with 0, pulse clr_i together with wr_en → busy_o high for 16 cycles, the write is dropped, and every pixel afterwards is 0.
- org (600,470) with W=512 → pixels x ≥ 600 up to 1023-bound inside the box render, and no wrap-around hits at x < 600.
- TEXT_LINE_BLINK_EN, BLINK_LOG2=1: write 'A' with blink=1 → lit for frames 0–1, blank for frames 2–3, lit again at frame 4. A non-blink neighbour is lit in all frames.

Source files
------------

// File: rtl/text_line_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | text_line_renderer: line buffer of N_CHARS glyph codes drawn as a scaled   |
// | text box, 3-cycle valid-tagged pixel pipeline, clear engine. Optional      |
// | per-character blink under macro TEXT_LINE_BLINK_EN.                        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module text_line_renderer #(
    parameter int N_CHARS    = 16,
    parameter int SCALE_LOG2 = 1,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(N_CHARS)-1:0] wr_addr,
    input  logic [4:0]                 wr_code,
    input  logic                       wr_blink,
    input  logic                       clr_i,
    output logic                       busy_o,
    input  logic [X_W-1:0]             org_x,
    input  logic [Y_W-1:0]             org_y,
    input  logic                       frame_start,
    input  logic                       pix_valid_i,
    input  logic [X_W-1:0]             pix_x,
    input  logic [Y_W-1:0]             pix_y,
    output logic                       pix_valid_o,
    output logic                       pix_on_o
);

    localparam int           AW         = $clog2(N_CHARS);
    localparam int           S          = SCALE_LOG2;
    localparam logic [X_W:0] BOX_W      = (X_W+1)'(N_CHARS * 16 * (1 << S));
    localparam logic [Y_W:0] BOX_H      = (Y_W+1)'(16 * (1 << S));
    localparam logic [4:0]   CODE_SPACE = 5'd26;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Glyphs are stored as 8x8 block shapes; each shape cell spans two rows and
    // two columns, shifted so column 0 is a half cell and column 15 is blank.
    function automatic logic [15:0] font_row(input logic [4:0] code, input logic [3:0] row);
        logic [63:0] g;
        logic [7:0]  b;
        case (code)
            5'd0:  g = 64'h3C66667E66666600;
            5'd1:  g = 64'h7C66667C66667C00;
            5'd2:  g = 64'h3C66606060663C00;
            5'd3:  g = 64'h786C6666666C7800;
            5'd4:  g = 64'h7E60607C60607E00;
            5'd5:  g = 64'h7E60607C60606000;
            5'd6:  g = 64'h3C66606E66663C00;
            5'd7:  g = 64'h6666667E66666600;
            5'd8:  g = 64'h3C18181818183C00;
            5'd9:  g = 64'h1E0C0C0C0C6C3800;
            5'd10: g = 64'h666C7870786C6600;
            5'd11: g = 64'h6060606060607E00;
            5'd12: g = 64'h63777F6B63636300;
            5'd13: g = 64'h66767E7E6E666600;
            5'd14: g = 64'h3C66666666663C00;
            5'd15: g = 64'h7C66667C60606000;
            5'd16: g = 64'h3C666666663C0E00;
            5'd17: g = 64'h7C66667C786C6600;
            5'd18: g = 64'h3C66603C06663C00;
            5'd19: g = 64'h7E18181818181800;
            5'd20: g = 64'h6666666666663C00;
            5'd21: g = 64'h66666666663C1800;
            5'd22: g = 64'h6363636B7F776300;
            5'd23: g = 64'h66663C183C666600;
            5'd24: g = 64'h6666663C18181800;
            5'd25: g = 64'h7E060C1830607E00;
            default: g = 64'h0;
        endcase
        b = g[{~row[3:1], 3'b000} +: 8];
        return {b[7], b[6], b[6], b[5], b[5], b[4], b[4], b[3],
                b[3], b[2], b[2], b[1], b[1], b[0], b[0], 1'b0};
    endfunction

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            busy_q;
    logic [4:0]      buf_q [N_CHARS];

    logic            buf_we_d;
    logic [AW-1:0]   buf_waddr_d;
    logic [4:0]      buf_wcode_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(N_CHARS - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A clear owns the write port; a clear request in IDLE drops a coincident write.
    always_comb begin
        buf_we_d    = 1'b0;
        buf_waddr_d = wr_addr;
        buf_wcode_d = wr_code;
        if (state_q == ST_CLEAR) begin
            buf_we_d    = 1'b1;
            buf_waddr_d = cnt_q;
            buf_wcode_d = CODE_SPACE;
        end else if (wr_en && !clr_i) begin
            buf_we_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_CHARS; i++) buf_q[i] <= CODE_SPACE;
        end else if (buf_we_d) begin
            buf_q[buf_waddr_d] <= buf_wcode_d;
        end
    end

    // Stage 1: offsets and box test at one extra bit so overrunning boxes never wrap.
    logic [X_W-1:0] dx_d, dx1_q;
    logic [Y_W-1:0] dy_d, dy1_q;
    logic           inside_d, in1_q, v1_q;

    assign dx_d     = pix_x - org_x;
    assign dy_d     = pix_y - org_y;
    assign inside_d = ({1'b0, pix_x} >= {1'b0, org_x}) && ({1'b0, pix_x} < ({1'b0, org_x} + BOX_W)) &&
                      ({1'b0, pix_y} >= {1'b0, org_y}) && ({1'b0, pix_y} < ({1'b0, org_y} + BOX_H));

    logic [X_W-1:0] char_sh_d, col_sh_d;
    logic [Y_W-1:0] row_sh_d;
    logic [AW-1:0]  char_d;

    assign char_sh_d = dx1_q >> (4 + S);
    assign col_sh_d  = dx1_q >> S;
    assign row_sh_d  = dy1_q >> S;
    assign char_d    = char_sh_d[AW-1:0];

    logic [4:0]  code2_q;
    logic [3:0]  col2_q, row2_q;
    logic        in2_q, v2_q, v3_q, on3_q;
    logic [15:0] row_word_d;
    logic        blank_phase_d;

    assign row_word_d = font_row(code2_q, row2_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dx1_q   <= '0;
            dy1_q   <= '0;
            in1_q   <= 1'b0;
            v1_q    <= 1'b0;
            code2_q <= CODE_SPACE;
            col2_q  <= '0;
            row2_q  <= '0;
            in2_q   <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            on3_q   <= 1'b0;
        end else begin
            dx1_q   <= dx_d;
            dy1_q   <= dy_d;
            in1_q   <= inside_d;
            v1_q    <= pix_valid_i;
            code2_q <= buf_q[char_d];
            col2_q  <= col_sh_d[3:0];
            row2_q  <= row_sh_d[3:0];
            in2_q   <= in1_q;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            on3_q   <= v2_q && in2_q && row_word_d[4'd15 - col2_q] && !blank_phase_d;
        end
    end

`ifdef TEXT_LINE_BLINK_EN
    logic                blink_q [N_CHARS];
    logic                blink2_q;
    logic [BLINK_LOG2:0] frame_cnt_q;
    logic                buf_wblink_d;

    assign buf_wblink_d = (state_q == ST_CLEAR) ? 1'b0 : wr_blink;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_CHARS; i++) blink_q[i] <= 1'b0;
            blink2_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (buf_we_d) blink_q[buf_waddr_d] <= buf_wblink_d;
            blink2_q <= blink_q[char_d];
            if (frame_start) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign blank_phase_d = frame_cnt_q[BLINK_LOG2] & blink2_q;
`else
    logic unused_blink;
    assign unused_blink  = ^{wr_blink, frame_start};
    assign blank_phase_d = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{char_sh_d[X_W-1:AW], col_sh_d[X_W-1:4], row_sh_d[Y_W-1:4]};

    assign busy_o      = busy_q;
    assign pix_valid_o = v3_q;
    assign pix_on_o    = on3_q;

endmodule
`default_nettype wire
